pipeline_execute_stage: RTL and testbench

Parametrised execute stage for the TSP16 pipeline. It sits between decode/regfile-read and writeback. It adds valid/ready handshaking, stall and flush, operand forwarding from its own output register and from writeback, and a multi-cycle multiply path. Its single-cycle ALU behaviour and done/dependent flags match the current stage.

---
 rtl/exec_pkg.sv | 41 ++++
 rtl/exec_alu.sv | 27 ++
 rtl/pipeline_execute_stage.sv | 134 +++++++++++++
 tb/tb_pipeline_execute_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings and decode helpers for the TSP16 execute stage.
package exec_pkg;

  localparam int TYPE_LO  = 14;
  localparam int FUNCT_LO = 9;
  localparam int RM_LO    = 6;
  localparam int RN_LO    = 3;
  localparam int RD_LO    = 0;

  localparam logic [1:0] R_TYPE  = 2'b00;
  localparam logic [1:0] A_TYPE  = 2'b01;
  localparam logic [3:0] LOAD_OP = 4'b1000;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic is_done(input logic [15:0] instr);
    return (instr[15:14] == R_TYPE) || (instr[15:14] == A_TYPE);
  endfunction

  // Anything that writes rd can feed a later instruction through forwarding.
  function automatic logic is_dependent(input logic [15:0] instr);
    return is_done(instr) || (instr[15:12] == LOAD_OP);
  endfunction

  function automatic logic is_mul(input logic [15:0] instr);
    return (instr[15:14] == R_TYPE) && (instr[11:9] == OP_MUL);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle ALU; only R-type instructions select by funct, all others add.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           funct,
  input  logic [1:0]        instr_type,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a + b;
    if (instr_type == R_TYPE) begin
      case (funct)
        OP_SUB:  result = a - b;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        default: result = a + b;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_execute_stage.sv
// TSP16 execute stage: handshaked ALU with operand forwarding and a
// multi-cycle multiply path sequenced by a small FSM.
module pipeline_execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MUL_CYCLES = 4,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [DATA_W-1:0]     rn_val,
  input  logic [DATA_W-1:0]     rm_val,
  output logic [REG_ADDR_W-1:0] rn_num,
  output logic [REG_ADDR_W-1:0] rm_num,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_num,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [DATA_W-1:0]     out_result,
  output logic                  out_done,
  output logic                  out_is_dependent,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

  state_t                                  state_reg;
  logic [CNT_W-1:0]                        count_reg;
  logic [DATA_W-1:0]                       mul_a_reg;
  logic [DATA_W-1:0]                       mul_b_reg;
  logic [INSTR_W-1:0]                      mul_instr_reg;
  logic [15:0]                             dec_instr;
  logic                                    accept;
  logic [1:0][REG_ADDR_W-1:0]              op_num;
  logic [1:0][DATA_W-1:0]                  op_raw;
  logic [1:0][DATA_W-1:0]                  op_val;
  logic [DATA_W-1:0]                       alu_result;
  logic [DATA_W-1:0]                       mul_result;

  assign dec_instr = in_instr[15:0];
  assign rn_num    = in_instr[RN_LO +: REG_ADDR_W];
  assign rm_num    = in_instr[RM_LO +: REG_ADDR_W];
  assign busy      = (state_reg == MUL);
  assign in_ready  = !busy && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  assign op_num[0] = rn_num;
  assign op_num[1] = rm_num;
  assign op_raw[0] = rn_val;
  assign op_raw[1] = rm_val;

  // The result sitting in our own output register is newer than writeback.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic fwd_ex;
      logic fwd_wb;
      assign fwd_ex = (FWD_EN != 0) && out_valid && out_is_dependent &&
                      (out_instr[RD_LO +: REG_ADDR_W] == op_num[gi]);
      assign fwd_wb = (FWD_EN != 0) && wb_valid && (wb_num == op_num[gi]);
      assign op_val[gi] = fwd_ex ? out_result :
                          fwd_wb ? wb_data    : op_raw[gi];
    end
  endgenerate

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .a          (op_val[0]),
    .b          (op_val[1]),
    .funct      (alu_op_t'(dec_instr[FUNCT_LO +: 3])),
    .instr_type (dec_instr[TYPE_LO +: 2]),
    .result     (alu_result)
  );

  assign mul_result = mul_a_reg * mul_b_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      mul_a_reg        <= '0;
      mul_b_reg        <= '0;
      mul_instr_reg    <= '0;
      out_valid        <= 1'b0;
      out_instr        <= '0;
      out_result       <= '0;
      out_done         <= 1'b0;
      out_is_dependent <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;

      if (flush) begin
        state_reg <= IDLE;
        count_reg <= '0;
        out_valid <= 1'b0;
      end else if (state_reg == MUL) begin
        if (count_reg > CNT_W'(1)) begin
          count_reg <= count_reg - CNT_W'(1);
        end else if (!out_valid || out_ready) begin
          // Completion waits here rather than clobber an unconsumed result.
          state_reg        <= IDLE;
          count_reg        <= '0;
          out_valid        <= 1'b1;
          out_instr        <= mul_instr_reg;
          out_result       <= mul_result;
          out_done         <= is_done(mul_instr_reg[15:0]);
          out_is_dependent <= is_dependent(mul_instr_reg[15:0]);
        end
      end else if (accept) begin
        if (is_mul(dec_instr)) begin
          state_reg     <= MUL;
          count_reg     <= CNT_W'(MUL_CYCLES - 1);
          mul_a_reg     <= op_val[0];
          mul_b_reg     <= op_val[1];
          mul_instr_reg <= in_instr;
        end else begin
          out_valid        <= 1'b1;
          out_instr        <= in_instr;
          out_result       <= alu_result;
          out_done         <= is_done(dec_instr);
          out_is_dependent <= is_dependent(dec_instr);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_execute_stage.sv
// Directed bench for pipeline_execute_stage; expected outputs are queued at
// issue time and a separate monitor compares them on each output handshake.
module tb_pipeline_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] rn_val;
  logic [15:0] rm_val;
  logic [2:0]  rn_num;
  logic [2:0]  rm_num;
  logic        wb_valid;
  logic [2:0]  wb_num;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_result;
  logic        out_done;
  logic        out_is_dependent;
  logic        busy;

  pipeline_execute_stage #(
    .DATA_W(16), .INSTR_W(16), .REG_ADDR_W(3), .MUL_CYCLES(4), .FWD_EN(1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .rn_val           (rn_val),
    .rm_val           (rm_val),
    .rn_num           (rn_num),
    .rm_num           (rm_num),
    .wb_valid         (wb_valid),
    .wb_num           (wb_num),
    .wb_data          (wb_data),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_result       (out_result),
    .out_done         (out_done),
    .out_is_dependent (out_is_dependent),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] result;
    logic        done;
    logic        dep;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_A = 2'b01;
  localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010,
                         F_OR = 3'b011, F_XOR = 3'b100, F_MUL = 3'b101;

  function automatic logic [15:0] enc(input logic [1:0] t, input logic [2:0] f,
                                      input logic [2:0] rm, input logic [2:0] rn,
                                      input logic [2:0] rd);
    return {t, 2'b00, f, rm, rn, rd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [15:0] ins, input logic [15:0] res,
                            input logic d, input logic dep);
    exp_q.push_back({ins, res, d, dep});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    in_instr = ins;
    rn_val   = a;
    rm_val   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rn_val   = '0;
    rm_val   = '0;
  endtask

  // Monitor: each output handshake consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got instr=0x%0h result=0x%0h, required no output",
                 out_instr, out_result);
      end else begin
        e = exp_q.pop_front();
        $display("txn instr=0x%04h result=0x%04h done=%0d dep=%0d", out_instr, out_result,
                 out_done, out_is_dependent);
        check("txn_instr",  32'(out_instr),        32'(e.instr));
        check("txn_result", 32'(out_result),       32'(e.result));
        check("txn_done",   32'(out_done),         32'(e.done));
        check("txn_dep",    32'(out_is_dependent), 32'(e.dep));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] v_ins [8];
  logic [15:0] v_a   [8];
  logic [15:0] v_b   [8];
  logic [15:0] v_res [8];
  logic        v_done[8];
  logic        v_dep [8];

  initial begin
    logic [15:0] add_r1, sub_r4, add_r3, and_r5, mul_r6, mul_fwd, add_r2, add_r7;

    add_r1  = enc(T_R, F_ADD, 3'd3, 3'd2, 3'd1);
    sub_r4  = enc(T_R, F_SUB, 3'd3, 3'd1, 3'd4);
    add_r3  = enc(T_R, F_ADD, 3'd5, 3'd4, 3'd3);
    and_r5  = enc(T_R, F_AND, 3'd3, 3'd2, 3'd5);
    mul_r6  = enc(T_R, F_MUL, 3'd3, 3'd2, 3'd6);
    mul_fwd = enc(T_R, F_MUL, 3'd3, 3'd1, 3'd6);
    add_r2  = enc(T_R, F_ADD, 3'd4, 3'd3, 3'd2);
    add_r7  = enc(T_R, F_ADD, 3'd3, 3'd2, 3'd7);

    v_ins[0] = enc(T_R, F_OR,  3'd3, 3'd2, 3'd7); v_a[0] = 16'h00F0; v_b[0] = 16'h000F; v_res[0] = 16'h00FF; v_done[0] = 1; v_dep[0] = 1;
    v_ins[1] = enc(T_R, F_XOR, 3'd3, 3'd2, 3'd7); v_a[1] = 16'h00FF; v_b[1] = 16'h000F; v_res[1] = 16'h00F0; v_done[1] = 1; v_dep[1] = 1;
    v_ins[2] = enc(T_R, F_SUB, 3'd3, 3'd2, 3'd7); v_a[2] = 16'h0003; v_b[2] = 16'h0005; v_res[2] = 16'hFFFE; v_done[2] = 1; v_dep[2] = 1;
    v_ins[3] = enc(T_R, F_ADD, 3'd3, 3'd2, 3'd7); v_a[3] = 16'hFFFF; v_b[3] = 16'h0002; v_res[3] = 16'h0001; v_done[3] = 1; v_dep[3] = 1;
    v_ins[4] = enc(T_R, F_AND, 3'd3, 3'd2, 3'd7); v_a[4] = 16'hF0F0; v_b[4] = 16'h0FF0; v_res[4] = 16'h00F0; v_done[4] = 1; v_dep[4] = 1;
    v_ins[5] = enc(T_A, F_SUB, 3'd3, 3'd2, 3'd7); v_a[5] = 16'd10;   v_b[5] = 16'd3;    v_res[5] = 16'd13;   v_done[5] = 1; v_dep[5] = 1;
    v_ins[6] = {4'b1000, F_SUB, 3'd3, 3'd2, 3'd7}; v_a[6] = 16'h0100; v_b[6] = 16'h0004; v_res[6] = 16'h0104; v_done[6] = 0; v_dep[6] = 1;
    v_ins[7] = {4'b1100, F_SUB, 3'd3, 3'd2, 3'd7}; v_a[7] = 16'd6;    v_b[7] = 16'd7;    v_res[7] = 16'd13;   v_done[7] = 0; v_dep[7] = 0;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; rn_val = '0; rm_val = '0;
    wb_valid = 1'b0; wb_num = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_flags", 32'({out_done, out_is_dependent}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step(2);
    rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic ADD, latency 1
    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    check("add_latency_valid", 32'(out_valid), 32'd1);
    check("add_latency_result", 32'(out_result), 32'd12);
    step(1);

    // EX forwarding on rn, back-to-back
    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    expect_out(sub_r4, 16'd10, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    issue(sub_r4, 16'd0, 16'd2);
    step(1);

    // WB forwarding with no EX match
    wb_valid = 1'b1; wb_num = 3'd1; wb_data = 16'd9;
    expect_out(sub_r4, 16'd7, 1'b1, 1'b1);
    issue(sub_r4, 16'd0, 16'd2);
    step(1);

    // EX beats WB when both match
    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    expect_out(sub_r4, 16'd10, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    issue(sub_r4, 16'd0, 16'd2);
    wb_valid = 1'b0;
    step(1);

    // EX forwarding on rm
    expect_out(add_r3, 16'd3, 1'b1, 1'b1);
    expect_out(and_r5, 16'd3, 1'b1, 1'b1);
    issue(add_r3, 16'd1, 16'd2);
    issue(and_r5, 16'h00FF, 16'd0);
    step(1);

    // ALU ops, wraparound and non-R types
    for (int i = 0; i < 8; i++) begin
      expect_out(v_ins[i], v_res[i], v_done[i], v_dep[i]);
      issue(v_ins[i], v_a[i], v_b[i]);
      step(1);
    end

    // Multi-cycle MUL: busy for 3 cycles, result in cycle 4
    expect_out(mul_r6, 16'h5F90, 1'b1, 1'b1);
    issue(mul_r6, 16'd300, 16'd300);
    check("mul_c1_busy", 32'(busy), 32'd1);
    check("mul_c1_in_ready", 32'(in_ready), 32'd0);
    check("mul_c1_out_valid", 32'(out_valid), 32'd0);
    step(1);
    check("mul_c2_busy", 32'(busy), 32'd1);
    step(1);
    check("mul_c3_busy", 32'(busy), 32'd1);
    check("mul_c3_out_valid", 32'(out_valid), 32'd0);
    step(1);
    check("mul_c4_busy", 32'(busy), 32'd0);
    check("mul_c4_out_valid", 32'(out_valid), 32'd1);
    check("mul_c4_result", 32'(out_result), 32'h5F90);
    step(1);

    // MUL operand latched from EX forwarding: 12 * 3
    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    expect_out(mul_fwd, 16'd36, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    issue(mul_fwd, 16'd0, 16'd3);
    step(5);

    // Backpressure holds the output and blocks acceptance
    out_ready = 1'b0;
    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    expect_out(add_r2, 16'd2, 1'b1, 1'b1);
    in_instr = add_r2; rn_val = 16'd1; rm_val = 16'd1; in_valid = 1'b1;
    check("hold_in_ready", 32'(in_ready), 32'd0);
    step(1);
    check("hold_result_1", 32'(out_result), 32'd12);
    check("hold_valid_1", 32'(out_valid), 32'd1);
    step(1);
    check("hold_result_2", 32'(out_result), 32'd12);
    out_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("hold_new_result", 32'(out_result), 32'd2);
    check("hold_new_valid", 32'(out_valid), 32'd1);
    step(1);

    // Flush in cycle 2 of a MUL
    issue(mul_r6, 16'd300, 16'd300);
    step(1);
    flush = 1'b1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step(1);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    step(3);
    check("flush_no_late_mul", 32'(out_valid), 32'd0);
    expect_out(add_r1, 16'd2, 1'b1, 1'b1);
    issue(add_r1, 16'd1, 16'd1);
    check("post_flush_result", 32'(out_result), 32'd2);
    step(1);

    // Flush kills a held output and refuses a same-cycle offer
    out_ready = 1'b0;
    issue(add_r7, 16'd3, 16'd4);
    flush = 1'b1;
    in_instr = add_r1; rn_val = 16'd1; rm_val = 16'd1; in_valid = 1'b1;
    check("flush_held_in_ready", 32'(in_ready), 32'd0);
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_held_valid", 32'(out_valid), 32'd0);
    step(1);
    check("flush_no_accept", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset with a held output
    out_ready = 1'b0;
    issue(add_r1, 16'd5, 16'd7);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_result", 32'(out_result), 32'd0);
    check("async_rst_instr", 32'(out_instr), 32'd0);
    check("async_rst_flags", 32'({out_done, out_is_dependent}), 32'd0);
    step(1);
    rst = 1'b0;
    out_ready = 1'b1;
    check("post_async_rst_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-MUL
    issue(mul_r6, 16'd300, 16'd300);
    step(1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mul_busy", 32'(busy), 32'd0);
    check("rst_mid_mul_valid", 32'(out_valid), 32'd0);
    step(1);
    rst = 1'b0;
    check("rst_mid_mul_in_ready", 32'(in_ready), 32'd1);
    step(5);
    check("rst_mid_mul_discard", 32'(out_valid), 32'd0);

    expect_out(add_r1, 16'd12, 1'b1, 1'b1);
    issue(add_r1, 16'd5, 16'd7);
    step(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
